// File: rtl/scan_chain_driver.sv
// Scan chain driver: shifts a stimulus pattern into one scan chain, pulses a capture
// cycle, then unloads the response while counting mismatches against an expected vector.
module scan_chain_driver #(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 CLK,
  input  logic                 CD,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic [CHAIN_LEN-1:0] EXP_IN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 FAIL,
  output logic [CNT_W-1:0]     MISMATCH_CNT,
  output logic [CHAIN_LEN-1:0] RESP_OUT
);

  localparam int IDX_W = $clog2(CHAIN_LEN);

  typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, FIN} state_t;

  state_t               state;
  logic [IDX_W-1:0]     cnt;
  logic [IDX_W-1:0]     cnt_nxt;
  logic                 last;
  logic [CHAIN_LEN-1:0] pat_sh;
  logic [CHAIN_LEN-1:0] exp_sh;
  logic [CNT_W-1:0]     mm_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(CHAIN_LEN)) ? v : v + 1'b1;
  endfunction

  assign cnt_nxt = cnt + 1'b1;
  assign last    = (cnt == IDX_W'(CHAIN_LEN - 1));
  assign mm_nxt  = (SO != exp_sh[cnt]) ? sat_inc(MISMATCH_CNT) : MISMATCH_CNT;

  // Shadows are pure data: captured on an accepted START, never reset.
  always_ff @(posedge CLK) begin
    if (state == IDLE && START) begin
      pat_sh <= PAT_IN;
      exp_sh <= EXP_IN;
    end
  end

  always_ff @(posedge CLK or posedge CD) begin
    if (CD) begin
      state        <= IDLE;
      SE           <= 1'b0;
      SI           <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      FAIL         <= 1'b0;
      MISMATCH_CNT <= '0;
      RESP_OUT     <= '0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          SE   <= 1'b0;
          SI   <= 1'b0;
          DONE <= 1'b0;
          if (START) begin
            MISMATCH_CNT <= '0;
            RESP_OUT     <= '0;
            FAIL         <= 1'b0;
            cnt          <= '0;
            SE           <= 1'b1;
            SI           <= PAT_IN[0];
            BUSY         <= 1'b1;
            state        <= LOAD;
          end
        end
        // SI is registered, so the bit for the next LOAD cycle is selected one edge early.
        LOAD: begin
          if (last) begin
            SE    <= 1'b0;
            SI    <= 1'b0;
            cnt   <= '0;
            state <= CAPTURE;
          end else begin
            cnt <= cnt_nxt;
            SI  <= pat_sh[cnt_nxt];
          end
        end
        CAPTURE: begin
          SE    <= 1'b1;
          SI    <= 1'b0;
          state <= UNLOAD;
        end
        UNLOAD: begin
          RESP_OUT[cnt] <= SO;
          MISMATCH_CNT  <= mm_nxt;
          if (last) begin
            SE    <= 1'b0;
            DONE  <= 1'b1;
            FAIL  <= (mm_nxt != '0);
            cnt   <= '0;
            state <= FIN;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        FIN: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver: 4-flop scan chain with inverting functional D inputs,
// directed cases plus randomized patterns checked against a behavioural model.
module tb_scan_chain_driver;

  localparam int L  = 4;
  localparam int CW = $clog2(L + 1);

  logic          CLK = 1'b0;
  logic          CD;
  logic          START;
  logic [L-1:0]  PAT_IN;
  logic [L-1:0]  EXP_IN;
  logic          SO;
  logic          SE;
  logic          SI;
  logic          BUSY;
  logic          DONE;
  logic          FAIL;
  logic [CW-1:0] MISMATCH_CNT;
  logic [L-1:0]  RESP_OUT;

  logic [L-1:0]  chain;

  int n_chk  = 0;
  int n_fail = 0;

  scan_chain_driver #(.CHAIN_LEN(L)) dut (
    .CLK          (CLK),
    .CD           (CD),
    .START        (START),
    .PAT_IN       (PAT_IN),
    .EXP_IN       (EXP_IN),
    .SO           (SO),
    .SE           (SE),
    .SI           (SI),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .FAIL         (FAIL),
    .MISMATCH_CNT (MISMATCH_CNT),
    .RESP_OUT     (RESP_OUT)
  );

  always #5 CLK = ~CLK;

  // chain[0] is fed by SI, chain[L-1] drives SO; capture inverts every flop.
  always @(posedge CLK) begin
    if (SE) chain <= {chain[L-2:0], SI};
    else    chain <= ~chain;
  end
  assign SO = chain[L-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Loading pat then inverting on capture means the i-th unloaded bit is ~pat[i].
  task automatic run_seq(input logic [L-1:0] pat, input logic [L-1:0] expv,
                         input bit repulse, input int abort_at);
    logic [L-1:0] rsp;
    int           mm;
    rsp = ~pat;
    mm  = $countones(rsp ^ expv);
    @(negedge CLK);
    PAT_IN = pat;
    EXP_IN = expv;
    START  = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge CLK);
      START = 1'b0;
      if (n == abort_at) begin
        CD = 1'b1;
        #1;
        check("abort_se",   32'(SE), 32'(0));
        check("abort_busy", 32'(BUSY), 32'(0));
        check("abort_mm",   32'(MISMATCH_CNT), 32'(0));
        check("abort_resp", 32'(RESP_OUT), 32'(0));
        check("abort_done", 32'(DONE), 32'(0));
        @(negedge CLK);
        CD = 1'b0;
        return;
      end
      check("se",   32'(SE),   32'((n >= 1 && n <= 4) || (n >= 6 && n <= 9)));
      check("busy", 32'(BUSY), 32'(n <= 10));
      check("done", 32'(DONE), 32'(n == 10));
      if (n <= 4) check("si", 32'(SI), 32'(pat[n-1]));
      if (n == 1) begin
        check("clr_fail", 32'(FAIL), 32'(0));
        check("clr_mm",   32'(MISMATCH_CNT), 32'(0));
        check("clr_resp", 32'(RESP_OUT), 32'(0));
      end
      if (n == 10) check("fail_at_done", 32'(FAIL), 32'(mm != 0));
      if (repulse && (n == 2 || n == 10)) begin
        START = 1'b1;
        if (n == 2) begin
          PAT_IN = L'($urandom);
          EXP_IN = L'($urandom);
        end
      end
    end
    check("resp", 32'(RESP_OUT), 32'(rsp));
    check("mm",   32'(MISMATCH_CNT), 32'(mm));
    check("fail", 32'(FAIL), 32'(mm != 0));
  endtask

  initial begin
    CD     = 1'b1;
    START  = 1'b0;
    PAT_IN = '0;
    EXP_IN = '0;
    #12;
    check("rst_se",   32'(SE), 32'(0));
    check("rst_si",   32'(SI), 32'(0));
    check("rst_busy", 32'(BUSY), 32'(0));
    check("rst_done", 32'(DONE), 32'(0));
    check("rst_fail", 32'(FAIL), 32'(0));
    check("rst_mm",   32'(MISMATCH_CNT), 32'(0));
    check("rst_resp", 32'(RESP_OUT), 32'(0));
    @(negedge CLK);
    CD = 1'b0;

    run_seq(4'b1010, 4'b0101, 1'b0, 0);
    run_seq(4'b1010, 4'b0110, 1'b0, 0);
    run_seq(4'b0000, 4'b0000, 1'b0, 0);
    run_seq(4'b1010, 4'b0101, 1'b1, 0);
    run_seq(4'b0110, 4'b1111, 1'b0, 7);
    run_seq(4'b1010, 4'b0101, 1'b0, 0);

    for (int k = 0; k < 10; k++) begin
      logic [L-1:0] p;
      logic [L-1:0] e;
      p = L'($urandom);
      e = ($urandom_range(0, 1) == 0) ? ~p : L'($urandom);
      run_seq(p, e, 1'($urandom_range(0, 1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
